// File: rtl/tt_um_calpoly_uart_tx.sv
// Buffered UART transmitter: strobed bytes are queued in a small FIFO and sent 8N1, LSB first, on uo_out[0].
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high; pops the next byte as soon as the FIFO is non-empty
// START  | start bit (tx=0)
// DATA   | eight data bits, LSB first
// PARITY | even parity over the data byte (UART_PARITY_EN builds only)
// STOP   | stop bit (tx=1)
module tt_um_calpoly_uart_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = (FIFO_DEPTH <= 2) ? 1 : (FIFO_DEPTH <= 4) ? 2 : 3;
  localparam int CW = AW + 1;
  localparam logic [7:0]    BIT_LOAD = 8'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_prev;
  logic          overflow;
  logic          full, empty;
  logic          push_req, push, pop;

  logic [7:0] timer, timer_next;
  logic [7:0] shreg, shreg_next;
  logic [2:0] bit_cnt, bit_next;
  logic       tx, tx_next;
`ifdef UART_PARITY_EN
  logic       par, par_next;
`endif

  logic [3:0] count_ext;
  logic [2:0] count_sat;
  logic       unused_ok;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_req = uio_in[0] & ~wr_prev & ena;
  // Fullness is judged before the edge, so a same-edge pop never rescues a push into a full FIFO.
  assign push     = push_req & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_prev  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_prev <= uio_in[0];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full)
        overflow <= 1'b1;
      else if (uio_in[1])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ui_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_next;
      tx      <= tx_next;
`ifdef UART_PARITY_EN
      par     <= par_next;
`endif
    end
  end

  // tx_next is the level for the coming bit period, so tx itself stays a clean register output.
  always_comb begin
    state_next = state;
    timer_next = timer;
    shreg_next = shreg;
    bit_next   = bit_cnt;
    tx_next    = tx;
    pop        = 1'b0;
`ifdef UART_PARITY_EN
    par_next   = par;
`endif
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = mem[rd_ptr];
`ifdef UART_PARITY_EN
          par_next   = ^mem[rd_ptr];
`endif
          tx_next    = 1'b0;
          timer_next = BIT_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (timer == '0) begin
          tx_next    = shreg[0];
          timer_next = BIT_LOAD;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_next = BIT_LOAD;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_next    = par;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            shreg_next = {1'b0, shreg[7:1]};
            tx_next    = shreg[1];
            bit_next   = bit_cnt + 3'd1;
          end
        end else begin
          timer_next = timer - 8'd1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (timer == '0) begin
          tx_next    = 1'b1;
          timer_next = BIT_LOAD;
          state_next = STOP;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (timer == '0)
          state_next = IDLE;
        else
          timer_next = timer - 8'd1;
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign count_ext = 4'(count);
  assign count_sat = (count_ext > 4'd7) ? 3'd7 : count_ext[2:0];

  assign uo_out    = {count_sat, overflow, empty, full, (state != IDLE) | ~empty, tx};
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ok = &{1'b0, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_calpoly_uart_tx.sv
// Directed bench for the buffered UART transmitter; a line monitor decodes frames against a scoreboard queue.
module tb_tt_um_calpoly_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FB     = NB * CLK_DIV;
  localparam int PERIOD = FB + 1;
  localparam logic [7:0] IDLE_UO = 8'b000_0_1_0_0_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  tt_um_calpoly_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rx_count = 0;
  int aborted  = 0;
  logic [7:0] exp_q[$];
  int start_t[$];
  logic prev_tx = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [FB-1:0] frame_wave(input logic [7:0] b);
    logic [NB-1:0] bits;
    logic [FB-1:0] w;
`ifdef UART_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    for (int j = 0; j < FB; j++) w[j] = bits[j / CLK_DIV];
    return w;
  endfunction

  // Samples every cycle of the frame so each bit must last exactly CLK_DIV cycles.
  task automatic rx_frame();
    logic [FB-1:0] obs;
    logic [7:0]    b;
    bit            ab;
    int            t0;
    ab = 1'b0;
    t0 = cyc;
    obs = '0;
    obs[0] = uo_out[0];
    for (int j = 1; j < FB; j++) begin
      @(negedge clk);
      if (!rst_n) begin
        ab = 1'b1;
        break;
      end
      obs[j] = uo_out[0];
    end
    if (ab) begin
      aborted++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      chk("unexpected_frame", 64'(exp_q.size()), 64'd1);
    end else begin
      b = exp_q.pop_front();
      chk($sformatf("frame_%02h", b), 64'(obs), 64'(frame_wave(b)));
      start_t.push_back(t0);
      rx_count++;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && prev_tx === 1'b1 && uo_out[0] === 1'b0) rx_frame();
      prev_tx = uo_out[0];
    end
  end

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    ui_in     = b;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n;
    n = 0;
    while (rx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rx_wait", 64'(rx_count), 64'(target));
  endtask

  initial begin : stim
    int base, sidx, lows, nfr;

    repeat (3) @(negedge clk);
    chk("reset_uo", uo_out, IDLE_UO);
    chk("reset_uio_oe", uio_oe, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_uo", uo_out, IDLE_UO);

    // Single byte: latency and exact waveform
    exp_q.push_back(8'hA5);
    strobe(8'hA5);
    chk("push_tx_high", uo_out[0], 1'b1);
    chk("push_not_empty", uo_out[3], 1'b0);
    @(negedge clk);
    chk("pop_tx_low", uo_out[0], 1'b0);
    chk("pop_empty", uo_out[3], 1'b1);
    chk("pop_busy", uo_out[1], 1'b1);
    wait_rx(1, PERIOD + 50);
    repeat (3) @(negedge clk);
    chk("idle_after_a5", uo_out, IDLE_UO);

    // Burst of six: one popped, four queued, sixth dropped
    base = rx_count;
    sidx = start_t.size();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(8'h11 * (i + 1)));
      strobe(8'(8'h11 * (i + 1)));
    end
    chk("burst_flags", uo_out[7:1], {3'd4, 1'b1, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    uio_in = 8'b0000_0011;
    @(negedge clk);
    uio_in = 8'h00;
    chk("ovf_set_wins", uo_out[4], 1'b1);
    chk("drop_count", uo_out[7:5], 3'd4);
    @(negedge clk);
    uio_in[1] = 1'b1;
    @(negedge clk);
    uio_in[1] = 1'b0;
    chk("ovf_clear", uo_out[4], 1'b0);
    chk("full_kept", uo_out[2], 1'b1);
    wait_rx(base + 5, 5 * PERIOD + 100);
    nfr = start_t.size() - sidx;
    chk("burst_frames", 64'(nfr), 64'd5);
    for (int i = 0; i + 1 < nfr; i++)
      chk($sformatf("b2b_period_%0d", i), 64'(start_t[sidx+i+1] - start_t[sidx+i]), 64'(PERIOD));

    // Held strobe pushes once
    repeat (3) @(negedge clk);
    base = rx_count;
    exp_q.push_back(8'h5A);
    ui_in     = 8'h5A;
    uio_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    uio_in[0] = 1'b0;
    wait_rx(base + 1, PERIOD + 50);
    repeat (PERIOD + 10) @(negedge clk);
    chk("hold_one_byte", 64'(rx_count - base), 64'd1);
    chk("hold_idle", uo_out, IDLE_UO);

    // ena low blocks pushes
    ena = 1'b0;
    strobe(8'hFF);
    chk("ena_low_no_push", uo_out, IDLE_UO);
    @(negedge clk);
    chk("ena_low_tx", uo_out, IDLE_UO);
    ena = 1'b1;

    // Reset during data bit 3 (0xC3 has bit3=0, so tx is low at that moment)
    exp_q.push_back(8'hC3);
    strobe(8'hC3);
    repeat (17) @(negedge clk);
    chk("pre_rst_tx_low", uo_out[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", uo_out[0], 1'b1);
    chk("rst_empty", uo_out[3], 1'b1);
    chk("rst_uo", uo_out, IDLE_UO);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = rx_count;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b1) lows++;
    end
    chk("no_residual", 64'(lows), 64'd0);
    chk("aborted_frames", 64'(aborted), 64'd1);
    chk("rx_after_rst", 64'(rx_count - base), 64'd0);
    chk("post_rst_idle", uo_out, IDLE_UO);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
